// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the fifo stream drain stage.
// The DRAIN_BEAT_COUNT_EN macro adds a pop counter port to fifo_stream_drain.
package fifo_stream_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } drain_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry register skid buffer in strict FIFO order.
// The head entry is always a register, so the payload never comes straight from push_data.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] entry_reg  [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] entry_next [SKID_DEPTH];
  logic [1:0]            count_reg;
  logic [1:0]            count_next;

  always_comb begin
    entry_next = entry_reg;
    count_next = count_reg;
    if (clear) begin
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) entry_next[0] = push_data;
          else                   entry_next[1] = push_data;
          if (count_reg != 2'd2) count_next = count_reg + 2'd1;
        end
        2'b01: begin
          entry_next[0] = entry_reg[1];
          if (count_reg != 2'd0) count_next = count_reg - 2'd1;
        end
        2'b11: begin
          // With one beat held, the arriving beat replaces the departing head
          if (count_reg == 2'd1) begin
            entry_next[0] = push_data;
          end else begin
            entry_next[0] = entry_reg[1];
            entry_next[1] = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= 2'd0;
      for (int i = 0; i < SKID_DEPTH; i++) entry_reg[i] <= '0;
    end else begin
      count_reg <= count_next;
      entry_reg <= entry_next;
    end
  end

  assign head_data = entry_reg[0];
  assign count     = count_reg;

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a 1-cycle-latency fifo into a valid/ready stream through a 2-entry skid buffer.
// Define DRAIN_BEAT_COUNT_EN to add the beat_count output (pops, modulo 2^32).
module fifo_stream_drain
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SKID_DEPTH = fifo_stream_pkg::SKID_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  flush_done
`ifdef DRAIN_BEAT_COUNT_EN
  ,
  output logic [31:0]           beat_count
`endif
);

  drain_state_e state_reg;
  logic         inflight_reg;
  logic         flush_done_reg;
  logic [1:0]   skid_count;
  logic [2:0]   credit_need;
  logic         pop;
  logic         grant;
  logic         in_run;

  assign in_run      = (state_reg == ST_RUN);
  assign out_valid   = (skid_count != 2'd0);
  assign pop         = out_valid & out_ready;
  // Slots that will be occupied once the in-flight beat lands and this cycle's pop leaves
  assign credit_need = {1'b0, skid_count} + {2'b00, inflight_reg} - {2'b00, pop};
  assign fifo_read   = reset & in_run & !fifo_empty & (credit_need < 3'(SKID_DEPTH));
  assign grant       = fifo_read & !fifo_empty;
  assign flush_done  = flush_done_reg;

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .clear    (in_run & flush),
    .push     (in_run & inflight_reg),
    .pop      (pop),
    .push_data(fifo_data),
    .head_data(out_data),
    .count    (skid_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_RUN;
      inflight_reg   <= 1'b0;
      flush_done_reg <= 1'b0;
    end else begin
      inflight_reg   <= grant;
      flush_done_reg <= 1'b0;
      if (in_run) begin
        if (flush) begin
          state_reg      <= ST_FLUSH;
          flush_done_reg <= !grant;
        end
      end else if (flush_done_reg) begin
        state_reg <= ST_RUN;
      end else begin
        // No reads are issued while flushing, so nothing is in flight next cycle
        flush_done_reg <= !grant;
      end
    end
  end

`ifdef DRAIN_BEAT_COUNT_EN
  logic [31:0] beat_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) beat_count_reg <= 32'd0;
    else if (pop) beat_count_reg <= beat_count_reg + 32'd1;
  end

  assign beat_count = beat_count_reg;
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: fifo model, stream scoreboard and per-scenario tasks.
`timescale 1ns/1ps
module tb_fifo_stream_drain;

  localparam int DW         = 32;
  localparam int FIFO_DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty;
  logic          fifo_read;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          flush_done;
`ifdef DRAIN_BEAT_COUNT_EN
  logic [31:0]   beat_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_stream_drain #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_read (fifo_read),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .flush_done(flush_done)
`ifdef DRAIN_BEAT_COUNT_EN
    ,
    .beat_count(beat_count)
`endif
  );

  // Upstream fifo: word at position p is 2*p; output_data is valid one cycle after a grant
  logic [DW-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_read && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push_word();
    mem[wr_ptr] = 32'(2 * wr_ptr);
    wr_ptr      = wr_ptr + 1;
  endtask

  // Reference model: granted words leave in order; flush or reset discards whatever is held
  int            cyc = 0;
  int            run_from = 0;
  int            done_at = -1;
  logic [DW-1:0] pend[$];
  logic [DW-1:0] obs[$];
  logic [DW-1:0] expq[$];
  int            grant_cyc[$];
  int            pop_cyc[$];
  int            viol = 0;
  int            done_err = 0;
  int            hold_err = 0;
  bit            hold_pend = 1'b0;
  logic [DW-1:0] held = '0;

  always @(posedge clk) begin : monitor
    bit m_run;
    bit m_pop;
    bit m_grant;
    bit m_exp_rd;
    if (!reset) begin
      pend.delete();
      run_from  = cyc + 1;
      done_at   = -1;
      hold_pend = 1'b0;
    end else begin
      m_run    = (cyc >= run_from);
      m_pop    = out_valid && out_ready;
      m_grant  = fifo_read && !fifo_empty;
      m_exp_rd = m_run && !fifo_empty && ((pend.size() - int'(m_pop)) < 2);
      if (fifo_read !== m_exp_rd) viol++;
      if (!m_run && out_valid) viol++;
      if (flush_done !== (cyc == done_at)) done_err++;
      if (hold_pend && (out_valid !== 1'b1 || out_data !== held)) hold_err++;
      if (m_pop) begin
        obs.push_back(out_data);
        pop_cyc.push_back(cyc);
        if (pend.size() == 0) expq.push_back(~out_data);
        else expq.push_back(pend.pop_front());
      end
      if (m_grant) begin
        pend.push_back(mem[rd_ptr]);
        grant_cyc.push_back(cyc);
      end
      hold_pend = out_valid && !out_ready;
      held      = out_data;
      if (m_run && flush) begin
        pend.delete();
        done_at   = cyc + (m_grant ? 2 : 1);
        run_from  = done_at + 1;
        hold_pend = 1'b0;
      end
    end
    cyc++;
  end

  task automatic clear_logs();
    obs.delete();
    expq.delete();
    grant_cyc.delete();
    pop_cyc.delete();
  endtask

  task automatic check_model(input string name, input int v0, input int d0, input int h0);
    int bad;
    bad = 0;
    for (int i = 0; i < obs.size(); i++) if (obs[i] !== expq[i]) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_order: %0d of %0d beats differ from model", name, bad, obs.size());
    end
    checks++;
    if (viol !== v0) begin
      errors++;
      $display("FAIL %s_read_rule: %0d violations, expected 0", name, viol - v0);
    end
    checks++;
    if (done_err !== d0) begin
      errors++;
      $display("FAIL %s_flush_done: %0d wrong cycles, expected 0", name, done_err - d0);
    end
    checks++;
    if (hold_err !== h0) begin
      errors++;
      $display("FAIL %s_hold: %0d unstable cycles, expected 0", name, hold_err - h0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    push_word();
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
    checks++;
    if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", flush_done); end
    checks++;
    if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", fifo_read); end
`ifdef DRAIN_BEAT_COUNT_EN
    checks++;
    if (beat_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", beat_count); end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_stream();
    int start_pos, bad, gaps, v0, d0, h0;
    v0 = viol; d0 = done_err; h0 = hold_err;
    clear_logs();
    start_pos = rd_ptr;
    out_ready = 1'b1;
    fork
      for (int c = 0; c < 200 && wr_ptr - start_pos < 32; c++) begin
        if (wr_ptr - rd_ptr < FIFO_DEPTH) push_word();
        @(negedge clk);
      end
      for (int c = 0; c < 300 && obs.size() < 32; c++) @(negedge clk);
    join
    checks++;
    if (obs.size() !== 32) begin errors++; $display("FAIL stream_count: got %0d beats expected 32", obs.size()); end
    bad = 0; gaps = 0;
    for (int i = 0; i < obs.size(); i++) begin
      if (obs[i] !== 32'(2 * (start_pos + i))) bad++;
      if (pop_cyc[i] !== pop_cyc[0] + i) gaps++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stream_data: %0d beats wrong, first got %0d expected %0d", bad, obs[0], 2 * start_pos); end
    checks++;
    if (gaps !== 0) begin errors++; $display("FAIL stream_gaps: %0d bubbles expected 0", gaps); end
    checks++;
    if (pop_cyc.size() == 0 || grant_cyc.size() == 0 || pop_cyc[0] - grant_cyc[0] !== 2) begin
      errors++;
      $display("FAIL stream_latency: first grant to first valid not 2 cycles");
    end
`ifdef DRAIN_BEAT_COUNT_EN
    checks++;
    if (beat_count !== 32'd32) begin errors++; $display("FAIL stream_beat_count: got %0d expected 32", beat_count); end
`endif
    check_model("stream", v0, d0, h0);
  endtask

  task automatic test_backpressure();
    int start_pos, bad, v0, d0, h0;
    v0 = viol; d0 = done_err; h0 = hold_err;
    clear_logs();
    start_pos = rd_ptr;
    fork
      for (int c = 0; c < 200 && wr_ptr - start_pos < 16; c++) begin
        if (wr_ptr - rd_ptr < FIFO_DEPTH) push_word();
        @(negedge clk);
      end
      for (int c = 0; c < 300 && obs.size() < 16; c++) begin
        out_ready = ~out_ready;
        @(negedge clk);
      end
    join
    out_ready = 1'b0;
    checks++;
    if (obs.size() !== 16) begin errors++; $display("FAIL bp_count: got %0d beats expected 16", obs.size()); end
    bad = 0;
    for (int i = 0; i < obs.size(); i++) if (obs[i] !== 32'(2 * (start_pos + i))) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_data: %0d beats lost, duplicated or reordered", bad); end
    check_model("bp", v0, d0, h0);
  endtask

  int stall_pos = 0;

  task automatic test_stall();
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    clear_logs();
    stall_pos = rd_ptr;
    for (int c = 0; c < 40 && wr_ptr - rd_ptr < FIFO_DEPTH; c++) begin
      push_word();
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (grant_cyc.size() !== 2) begin errors++; $display("FAIL stall_reads: got %0d reads expected 2", grant_cyc.size()); end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", out_valid); end
    checks++;
    if (out_data !== 32'(2 * stall_pos)) begin errors++; $display("FAIL stall_data: got %0d expected %0d", out_data, 2 * stall_pos); end
    checks++;
    if (fifo_read !== 1'b0 || wr_ptr - rd_ptr !== FIFO_DEPTH) begin
      errors++;
      $display("FAIL stall_full: read=%b fifo level %0d expected read=0 level %0d", fifo_read, wr_ptr - rd_ptr, FIFO_DEPTH);
    end
  endtask

  task automatic test_flush();
    int v0, d0, h0;
    logic [31:0] bc;
    v0 = viol; d0 = done_err; h0 = hold_err;
    clear_logs();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    flush     = 1'b1;
    bc        = '0;
`ifdef DRAIN_BEAT_COUNT_EN
    bc = beat_count;
`endif
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (flush_done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_pulse: done=%b valid=%b expected done=1 valid=0", flush_done, out_valid);
    end
    @(negedge clk);
    checks++;
    if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_single: got %b expected 0", flush_done); end
`ifdef DRAIN_BEAT_COUNT_EN
    checks++;
    if (beat_count !== bc) begin errors++; $display("FAIL flush_count: got %0d expected %0d", beat_count, bc); end
`else
    checks++;
    if (bc !== 32'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", bc); end
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 50 && obs.size() < 2; c++) @(negedge clk);
    checks++;
    if (obs.size() < 2 || obs[0] !== 32'(2 * stall_pos) || obs[1] !== 32'(2 * (stall_pos + 3))) begin
      errors++;
      $display("FAIL flush_next: got %0d beats, second %0d expected %0d then %0d", obs.size(),
               (obs.size() > 1) ? obs[1] : 32'd0, 2 * stall_pos, 2 * (stall_pos + 3));
    end
    check_model("flush", v0, d0, h0);
  endtask

  task automatic test_reset_mid();
    int head_pos, v0, d0, h0;
    v0 = viol; d0 = done_err; h0 = hold_err;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (wr_ptr - rd_ptr < FIFO_DEPTH) push_word();
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_read !== 1'b0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b read=%b data=%0d expected 0 0 0", out_valid, fifo_read, out_data);
    end
`ifdef DRAIN_BEAT_COUNT_EN
    checks++;
    if (beat_count !== 32'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", beat_count); end
`endif
    repeat (2) @(negedge clk);
    clear_logs();
    head_pos = rd_ptr;
    reset    = 1'b1;
    for (int c = 0; c < 50 && obs.size() < 4; c++) @(negedge clk);
    checks++;
    if (obs.size() < 4 || obs[0] !== 32'(2 * head_pos)) begin
      errors++;
      $display("FAIL reset_resume: got %0d beats, first %0d expected %0d", obs.size(),
               (obs.size() > 0) ? obs[0] : 32'd0, 2 * head_pos);
    end
    check_model("reset_mid", v0, d0, h0);
  endtask

  task automatic test_random();
    int v0, d0, h0, flushes;
    v0 = viol; d0 = done_err; h0 = hold_err;
    flushes = 0;
    clear_logs();
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && wr_ptr - rd_ptr < FIFO_DEPTH) push_word();
      flush = (cyc >= run_from) && ($urandom_range(0, 19) == 0);
      if (flush) flushes++;
      @(negedge clk);
      flush = 1'b0;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 100 && !(fifo_empty && !out_valid); c++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (obs.size() !== expq.size() || obs.size() == 0) begin
      errors++;
      $display("FAIL random_beats: got %0d beats, model has %0d", obs.size(), expq.size());
    end
    checks++;
    if (!fifo_empty || out_valid) begin errors++; $display("FAIL random_drain: empty=%b valid=%b expected 1 0", fifo_empty, out_valid); end
    check_model("random", v0, d0, h0);
    $display("random: %0d cycles, %0d beats, %0d flushes", 400, obs.size(), flushes);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
